// File: rtl/random_pulse_pkg.sv
// Shared state type, LFSR step and spacing scaling for the random pulse channels.
// Pure combinational helpers; every channel evaluates them on its own state.
package random_pulse_pkg;

  localparam logic [31:0] c_lfsr_taps = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} t_pulse_state;

  // Right-shifting Galois step: the taps are folded in when bit 0 falls out.
  function automatic logic [31:0] f_lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ c_lfsr_taps) : (s >> 1);
  endfunction

  // Maps a w-bit random value onto [mn, mx]; an inverted range collapses to mn.
  function automatic logic [31:0] f_scale_spacing(input logic [31:0] r,
                                                  input logic [31:0] mn,
                                                  input logic [31:0] mx,
                                                  input int unsigned w);
    logic [32:0] span1;
    logic [64:0] prod;
    span1 = (mx >= mn) ? ({1'b0, mx} - {1'b0, mn} + 33'd1) : 33'd1;
    prod  = {33'd0, r} * {32'd0, span1};
    return mn + 32'(prod >> w);
  endfunction

endpackage

// File: rtl/random_pulse_chan.sv
// One pulse channel: IDLE/HIGH/LOW FSM, private LFSR, width/spacing/burst counters.
// Latency: enable sampled at edge k -> pulse_o high after edge k+1.
// Backpressure: none; outputs are free-running registered strobes.
module random_pulse_chan
  import random_pulse_pkg::*;
#(
  parameter int unsigned g_cnt_width = 16,
  parameter logic [31:0] g_seed      = 32'h0000_0001
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_i,
  input  logic                   enable_i,
  input  logic                   mode_burst_i,
  input  logic [g_cnt_width-1:0] burst_count_i,
  input  logic [g_cnt_width-1:0] width_i,
  input  logic [g_cnt_width-1:0] min_spacing_i,
  input  logic [g_cnt_width-1:0] max_spacing_i,
  output logic                   pulse_o,
  output logic                   busy_o,
  output logic                   done_p_o
);

  localparam logic [g_cnt_width-1:0] c_one = g_cnt_width'(1);

  t_pulse_state           state;
  logic [31:0]            lfsr;
  logic                   en_q;
  logic                   start_q;
  logic                   burst_q;
  logic [g_cnt_width-1:0] cnt;
  logic [g_cnt_width-1:0] low_len;
  logic [g_cnt_width-1:0] rem;

  logic [g_cnt_width-1:0] w_eff;
  logic [g_cnt_width-1:0] s_draw;
  logic [g_cnt_width-1:0] low_draw;
  logic                   trig;

  // Spacing is drawn from the LFSR value before it advances on HIGH entry.
  assign w_eff    = (width_i == '0) ? c_one : width_i;
  assign s_draw   = g_cnt_width'(f_scale_spacing(32'(lfsr[g_cnt_width-1:0]),
                                                 32'(min_spacing_i),
                                                 32'(max_spacing_i),
                                                 g_cnt_width));
  assign low_draw = (s_draw > w_eff) ? s_draw - w_eff : c_one;
  assign trig     = mode_burst_i ? (enable_i & ~en_q) : enable_i;

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state    <= IDLE;
      lfsr     <= g_seed;
      en_q     <= 1'b0;
      start_q  <= 1'b0;
      burst_q  <= 1'b0;
      cnt      <= '0;
      low_len  <= '0;
      rem      <= '0;
      pulse_o  <= 1'b0;
      busy_o   <= 1'b0;
      done_p_o <= 1'b0;
    end else begin
      en_q     <= enable_i;
      start_q  <= 1'b0;
      done_p_o <= 1'b0;
      unique case (state)
        IDLE: begin
          // start_q adds the one-cycle gap between trigger and first pulse.
          if (start_q) begin
            rem <= burst_count_i;
            if (burst_q && burst_count_i == '0) begin
              done_p_o <= 1'b1;
            end else begin
              state   <= HIGH;
              pulse_o <= 1'b1;
              busy_o  <= 1'b1;
              lfsr    <= f_lfsr_next(lfsr);
              cnt     <= w_eff - c_one;
              low_len <= low_draw;
            end
          end else if (trig) begin
            start_q <= 1'b1;
            burst_q <= mode_burst_i;
          end
        end
        HIGH: begin
          if (cnt != '0) begin
            cnt <= cnt - c_one;
          end else begin
            pulse_o <= 1'b0;
            if (enable_i) begin
              state <= LOW;
              cnt   <= low_len - c_one;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
        end
        LOW: begin
          if (!enable_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - c_one;
          end else if (burst_q && rem == c_one) begin
            state    <= IDLE;
            busy_o   <= 1'b0;
            done_p_o <= 1'b1;
          end else begin
            if (burst_q) rem <= rem - c_one;
            state   <= HIGH;
            pulse_o <= 1'b1;
            lfsr    <= f_lfsr_next(lfsr);
            cnt     <= w_eff - c_one;
            low_len <= low_draw;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/random_pulse_gen_mc.sv
// Multi-channel random pulse source; one independent channel per enable bit.
// Latency: enable sampled at edge k -> pulse_o high after edge k+1.
// Backpressure: none; pulse/busy/done are registered per-channel outputs.
module random_pulse_gen_mc
  import random_pulse_pkg::*;
#(
  parameter int unsigned g_num_channels = 4,
  parameter int unsigned g_cnt_width    = 16,
  parameter logic [31:0] g_lfsr_seed    = 32'h0000_0001
) (
  input  logic                      clk_sys_i,
  input  logic                      rst_sys_i,
  input  logic [g_num_channels-1:0] enable_i,
  input  logic                      mode_burst_i,
  input  logic [g_cnt_width-1:0]    burst_count_i,
  input  logic [g_cnt_width-1:0]    width_i,
  input  logic [g_cnt_width-1:0]    min_spacing_i,
  input  logic [g_cnt_width-1:0]    max_spacing_i,
  output logic [g_num_channels-1:0] pulse_o,
  output logic [g_num_channels-1:0] busy_o,
  output logic [g_num_channels-1:0] done_p_o
);

  for (genvar c = 0; c < g_num_channels; c++) begin : g_chan
    random_pulse_chan #(
      .g_cnt_width(g_cnt_width),
      .g_seed     (g_lfsr_seed + 32'(c))
    ) u_chan (
      .clk_sys_i    (clk_sys_i),
      .rst_sys_i    (rst_sys_i),
      .enable_i     (enable_i[c]),
      .mode_burst_i (mode_burst_i),
      .burst_count_i(burst_count_i),
      .width_i      (width_i),
      .min_spacing_i(min_spacing_i),
      .max_spacing_i(max_spacing_i),
      .pulse_o      (pulse_o[c]),
      .busy_o       (busy_o[c]),
      .done_p_o     (done_p_o[c])
    );
  end

endmodule

// File: tb/tb_random_pulse_gen_mc.sv
// Scenario bench for random_pulse_gen_mc with a per-cycle expected-value queue
// and an independent LFSR/spacing model for the randomised spacing run.
module tb_random_pulse_gen_mc;

  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic           clk_sys_i = 1'b0;
  logic           rst_sys_i = 1'b1;
  logic [NCH-1:0] enable_i = '0;
  logic           mode_burst_i = 1'b0;
  logic [CW-1:0]  burst_count_i = '0;
  logic [CW-1:0]  width_i = '0;
  logic [CW-1:0]  min_spacing_i = '0;
  logic [CW-1:0]  max_spacing_i = '0;
  logic [NCH-1:0] pulse_o;
  logic [NCH-1:0] busy_o;
  logic [NCH-1:0] done_p_o;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  int          exp_rq[NCH][$];
  int          sp[NCH][1000];

  always #5 clk_sys_i = ~clk_sys_i;

  random_pulse_gen_mc #(
    .g_num_channels(NCH),
    .g_cnt_width   (CW),
    .g_lfsr_seed   (SEED)
  ) dut (
    .clk_sys_i    (clk_sys_i),
    .rst_sys_i    (rst_sys_i),
    .enable_i     (enable_i),
    .mode_burst_i (mode_burst_i),
    .burst_count_i(burst_count_i),
    .width_i      (width_i),
    .min_spacing_i(min_spacing_i),
    .max_spacing_i(max_spacing_i),
    .pulse_o      (pulse_o),
    .busy_o       (busy_o),
    .done_p_o     (done_p_o)
  );

  function automatic logic [31:0] m_lfsr_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  function automatic int m_spacing(input logic [31:0] st, input int mn, input int mx);
    longint span;
    longint r;
    span = (mx >= mn) ? longint'(mx - mn) : 64'sd0;
    r    = longint'(st[15:0]);
    return mn + int'((r * (span + 1)) >> 16);
  endfunction

  task automatic tick();
    @(posedge clk_sys_i);
    #1;
  endtask

  task automatic do_reset();
    rst_sys_i = 1'b1;
    enable_i  = '0;
    repeat (2) tick();
    rst_sys_i = 1'b0;
  endtask

  task automatic set_cfg(input logic burst, input int cnt, input int w, input int mn, input int mx);
    mode_burst_i  = burst;
    burst_count_i = CW'(cnt);
    width_i       = CW'(w);
    min_spacing_i = CW'(mn);
    max_spacing_i = CW'(mx);
  endtask

  task automatic test_reset();
    rst_sys_i = 1'b1;
    enable_i  = '1;
    set_cfg(1'b0, 0, 3, 10, 10);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({pulse_o, busy_o, done_p_o} !== 12'h000) begin
        errors++;
        $display("FAIL reset[%0d]: pulse=%b busy=%b done=%b, required all 0", i, pulse_o, busy_o, done_p_o);
      end
    end
    enable_i  = '0;
    rst_sys_i = 1'b0;
  endtask

  task automatic test_fixed_period();
    logic [11:0] e;
    do_reset();
    set_cfg(1'b0, 0, 3, 10, 10);
    enable_i = 4'b0001;
    for (int j = 0; j <= 40; j++)
      exp_q.push_back((j >= 1 && ((j - 1) % 10) < 3) ? 12'h001 : 12'h000);
    for (int j = 0; j <= 40; j++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({8'h00, pulse_o} !== e) begin
        errors++;
        $display("FAIL fixed_period j=%0d: pulse=%b, required %b", j, pulse_o, e[3:0]);
      end
    end
    enable_i = '0;
  endtask

  task automatic test_random();
    logic [31:0]    m_lfsr[NCH];
    int             last_rise[NCH];
    int             npulse[NCH];
    logic [NCH-1:0] prev;
    int             t, meas, ex, s, diff;
    bit             all_done;
    do_reset();
    set_cfg(1'b0, 0, 2, 20, 40);
    for (int c = 0; c < NCH; c++) begin
      m_lfsr[c]    = SEED + 32'(c);
      last_rise[c] = 0;
      npulse[c]    = 0;
      exp_rq[c].delete();
    end
    prev     = '0;
    all_done = 1'b0;
    t        = 0;
    enable_i = '1;
    while (!all_done && t < 40000) begin
      tick();
      t++;
      for (int c = 0; c < NCH; c++) begin
        if (pulse_o[c] && !prev[c]) begin
          if (npulse[c] > 0 && exp_rq[c].size() > 0) begin
            meas = t - last_rise[c];
            ex   = exp_rq[c].pop_front();
            if (npulse[c] <= 1000) sp[c][npulse[c] - 1] = meas;
            checks++;
            if (meas != ex) begin
              errors++;
              $display("FAIL random ch%0d pulse %0d: spacing=%0d, required %0d", c, npulse[c], meas, ex);
            end
            checks++;
            if (meas < 20 || meas > 40) begin
              errors++;
              $display("FAIL random_range ch%0d pulse %0d: spacing=%0d, required 20..40", c, npulse[c], meas);
            end
          end
          s = m_spacing(m_lfsr[c], 20, 40);
          exp_rq[c].push_back((s > 3) ? s : 3);
          m_lfsr[c]    = m_lfsr_next(m_lfsr[c]);
          last_rise[c] = t;
          npulse[c]++;
        end
      end
      prev     = pulse_o;
      all_done = 1'b1;
      for (int c = 0; c < NCH; c++)
        if (npulse[c] <= 1000) all_done = 1'b0;
    end
    enable_i = '0;
    checks++;
    if (!all_done) begin
      errors++;
      $display("FAIL random_timeout: pulses ch0..3=%0d/%0d/%0d/%0d, required >1000 each",
               npulse[0], npulse[1], npulse[2], npulse[3]);
    end else begin
      for (int c = 1; c < NCH; c++) begin
        diff = 0;
        for (int k = 0; k < 1000; k++)
          if (sp[0][k] != sp[c][k]) diff++;
        checks++;
        if (diff == 0) begin
          errors++;
          $display("FAIL random_distinct ch0 vs ch%0d: differing spacings=%0d, required >0", c, diff);
        end
      end
    end
  endtask

  task automatic test_burst();
    logic [11:0] e, o;
    int          npul;
    logic        prevp;
    do_reset();
    set_cfg(1'b1, 5, 4, 12, 12);
    enable_i = 4'b0100;
    for (int j = 0; j <= 80; j++)
      exp_q.push_back({9'd0, (j >= 1 && j <= 60), (j == 61),
                       (j >= 1 && j <= 60 && ((j - 1) % 12) < 4)});
    npul  = 0;
    prevp = 1'b0;
    for (int j = 0; j <= 80; j++) begin
      tick();
      e = exp_q.pop_front();
      o = {9'd0, busy_o[2], done_p_o[2], pulse_o[2]};
      if (pulse_o[2] && !prevp) npul++;
      prevp = pulse_o[2];
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL burst j=%0d: busy/done/pulse=%b, required %b", j, o[2:0], e[2:0]);
      end
    end
    checks++;
    if (npul != 5) begin
      errors++;
      $display("FAIL burst_count: pulses=%0d, required 5", npul);
    end
    enable_i = '0;
  endtask

  task automatic test_edge();
    int          w, mn, we, per;
    logic [11:0] e;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       begin w = 0;  mn = 5;  we = 1;  per = 5;  end
        1:       begin w = 10; mn = 4;  we = 10; per = 11; end
        default: begin w = 3;  mn = 0;  we = 3;  per = 4;  end
      endcase
      do_reset();
      set_cfg(1'b0, 0, w, mn, mn);
      enable_i = 4'b0010;
      for (int j = 0; j <= 35; j++)
        exp_q.push_back((j >= 1 && ((j - 1) % per) < we) ? 12'h002 : 12'h000);
      for (int j = 0; j <= 35; j++) begin
        tick();
        e = exp_q.pop_front();
        checks++;
        if ({8'h00, pulse_o} !== e) begin
          errors++;
          $display("FAIL edge%0d j=%0d: pulse=%b, required %b", k, j, pulse_o, e[3:0]);
        end
      end
      enable_i = '0;
    end
    do_reset();
    set_cfg(1'b1, 0, 4, 12, 12);
    enable_i = 4'b0010;
    for (int j = 0; j <= 10; j++)
      exp_q.push_back((j == 1) ? 12'h002 : 12'h000);
    for (int j = 0; j <= 10; j++) begin
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({pulse_o, busy_o, done_p_o} !== e) begin
        errors++;
        $display("FAIL burst_zero j=%0d: pulse=%b busy=%b done=%b, required done=%b only",
                 j, pulse_o, busy_o, done_p_o, e[3:0]);
      end
    end
    enable_i = '0;
  endtask

  task automatic test_abort();
    logic [11:0] e, o;
    do_reset();
    set_cfg(1'b0, 0, 8, 20, 20);
    enable_i = 4'b0001;
    for (int j = 0; j <= 30; j++)
      exp_q.push_back((j >= 1 && j <= 8) ? 12'h003 : 12'h000);
    for (int j = 0; j <= 30; j++) begin
      tick();
      e = exp_q.pop_front();
      o = {10'd0, busy_o[0], pulse_o[0]};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort_high j=%0d: busy/pulse=%b, required %b", j, o[1:0], e[1:0]);
      end
      if (j == 3) enable_i = '0;
    end

    do_reset();
    set_cfg(1'b1, 5, 4, 12, 12);
    enable_i = 4'b1000;
    for (int j = 0; j <= 30; j++)
      exp_q.push_back({9'd0, (j >= 1 && j <= 6), 1'b0, (j >= 1 && j <= 4)});
    for (int j = 0; j <= 30; j++) begin
      tick();
      e = exp_q.pop_front();
      o = {9'd0, busy_o[3], done_p_o[3], pulse_o[3]};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort_low j=%0d: busy/done/pulse=%b, required %b", j, o[2:0], e[2:0]);
      end
      if (j == 6) enable_i = '0;
    end

    do_reset();
    set_cfg(1'b0, 0, 8, 20, 20);
    enable_i = 4'b0001;
    repeat (4) tick();
    checks++;
    if (pulse_o !== 4'b0001) begin
      errors++;
      $display("FAIL reset_mid_pre: pulse=%b, required 0001", pulse_o);
    end
    rst_sys_i = 1'b1;
    tick();
    checks++;
    if ({pulse_o, busy_o} !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: pulse=%b busy=%b, required 0", pulse_o, busy_o);
    end
    rst_sys_i = 1'b0;
    enable_i  = '0;
  endtask

  initial begin
    test_reset();
    test_fixed_period();
    test_random();
    test_burst();
    test_edge();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
